// File: rtl/ad9648_spi_responder_if.sv
// SPI pin bundle between an AD9648-style configuration master and the responder.
// The master drives SCK/CS/MOSI; the responder answers on MISO with its own enable.
interface ad9648_spi_responder_if;
  logic sck;
  logic cs;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sck, output cs, output mosi, input miso, input miso_oe);
  modport slave  (input sck, input cs, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/ad9648_spi_responder.sv
// Mode-0 SPI target for 24-bit AD9648 frames: 16-bit instruction plus one data byte,
// with shadow/active register banks, a transfer register at 0xFF and a fixed chip ID at 0x01.
module ad9648_spi_responder #(
  parameter int unsigned RegCount  = 16,
  parameter logic [7:0]  ChipId    = 8'h88,
  parameter int unsigned FrameBits = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_clk_i,
  ad9648_spi_responder_if.slave   spi,
  output logic                    wr_strobe_o,
  output logic [12:0]             wr_addr_o,
  output logic [7:0]              wr_data_o,
  output logic                    update_o,
  output logic                    frame_err_o,
  output logic [RegCount*8-1:0]   active_regs_o
);

  localparam logic [4:0]  InstrLast  = 5'(FrameBits - 9);
  localparam logic [4:0]  FrameLast  = 5'(FrameBits - 1);
  localparam logic [12:0] RegCountW  = 13'(RegCount);
  localparam logic [12:0] AddrChipId = 13'h001;
  localparam logic [12:0] AddrXfer   = 13'h0FF;

  typedef enum logic [2:0] {
    WAIT_CSH,
    IDLE,
    INSTR,
    DATA,
    COMMIT,
    DONE
  } state_e;

  state_e                state_q;
  logic [1:0]            sckSync_q;
  logic [1:0]            csSync_q;
  logic [1:0]            mosiSync_q;
  logic                  sckPrev_q;
  logic                  csPrev_q;
  logic [4:0]            bitCnt_q;
  logic [14:0]           instShift_q;
  logic                  rnw_q;
  logic [12:0]           addr_q;
  logic [7:0]            dataShift_q;
  logic [7:0]            readShift_q;
  logic                  miso_q;
  logic                  misoOe_q;
  logic                  wrStrobe_q;
  logic [12:0]           wrAddr_q;
  logic [7:0]            wrData_q;
  logic                  update_q;
  logic                  frameErr_q;
  logic [RegCount*8-1:0] shadow_q;
  logic [RegCount*8-1:0] active_q;

  logic                  sckS;
  logic                  csS;
  logic                  mosiS;
  logic                  sckRise;
  logic                  sckFall;
  logic                  csFall;
  logic [12:0]           rdAddr;
  logic [7:0]            readByte_d;

  assign sckS    = sckSync_q[1];
  assign csS     = csSync_q[1];
  assign mosiS   = mosiSync_q[1];
  assign sckRise = sckS & ~sckPrev_q;
  assign sckFall = ~sckS & sckPrev_q;
  assign csFall  = ~csS & csPrev_q;

  // Read byte is chosen from the address as it completes on the 16th rising edge.
  always_comb begin
    rdAddr     = {instShift_q[11:0], mosiS};
    readByte_d = 8'h00;
    if (rdAddr == AddrChipId) begin
      readByte_d = ChipId;
    end else if (rdAddr < RegCountW) begin
      for (int i = 0; i < int'(RegCount); i++) begin
        if (rdAddr == 13'(i)) readByte_d = shadow_q[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_clk_i) begin
    if (!rst_clk_i) begin
      state_q     <= WAIT_CSH;
      sckSync_q   <= '0;
      csSync_q    <= '0;
      mosiSync_q  <= '0;
      sckPrev_q   <= 1'b0;
      csPrev_q    <= 1'b0;
      bitCnt_q    <= '0;
      instShift_q <= '0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      dataShift_q <= '0;
      readShift_q <= '0;
      miso_q      <= 1'b0;
      misoOe_q    <= 1'b0;
      wrStrobe_q  <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      update_q    <= 1'b0;
      frameErr_q  <= 1'b0;
      shadow_q    <= '0;
      active_q    <= '0;
    end else begin
      sckSync_q  <= {sckSync_q[0], spi.sck};
      csSync_q   <= {csSync_q[0], spi.cs};
      mosiSync_q <= {mosiSync_q[0], spi.mosi};
      sckPrev_q  <= sckS;
      csPrev_q   <= csS;
      wrStrobe_q <= 1'b0;
      update_q   <= 1'b0;
      frameErr_q <= 1'b0;

      case (state_q)
        WAIT_CSH: begin
          if (csS) state_q <= IDLE;
        end
        IDLE: begin
          if (csFall) begin
            bitCnt_q <= '0;
            state_q  <= INSTR;
          end
        end
        // An SCK edge seen together with CS high is consumed first; CS is a level, so an
        // unfinished frame still aborts on the following cycle.
        INSTR: begin
          if (sckRise) begin
            instShift_q <= {instShift_q[13:0], mosiS};
            bitCnt_q    <= bitCnt_q + 5'd1;
            if (bitCnt_q == InstrLast) begin
              rnw_q       <= instShift_q[14];
              addr_q      <= rdAddr;
              readShift_q <= readByte_d;
              state_q     <= DATA;
            end
          end else if (csS) begin
            frameErr_q <= 1'b1;
            misoOe_q   <= 1'b0;
            miso_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        DATA: begin
          if (sckRise) begin
            dataShift_q <= {dataShift_q[6:0], mosiS};
            bitCnt_q    <= bitCnt_q + 5'd1;
            if (bitCnt_q == FrameLast) state_q <= rnw_q ? DONE : COMMIT;
          end else if (sckFall && rnw_q) begin
            miso_q      <= readShift_q[7];
            readShift_q <= {readShift_q[6:0], 1'b0};
            misoOe_q    <= 1'b1;
          end else if (csS) begin
            frameErr_q <= 1'b1;
            misoOe_q   <= 1'b0;
            miso_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        // Every write frame strobes, even when the address is not backed by storage.
        COMMIT: begin
          wrStrobe_q <= 1'b1;
          wrAddr_q   <= addr_q;
          wrData_q   <= dataShift_q;
          if (addr_q == AddrXfer) begin
            if (dataShift_q[0]) begin
              active_q <= shadow_q;
              update_q <= 1'b1;
            end
          end else if (addr_q != AddrChipId && addr_q < RegCountW) begin
            for (int i = 0; i < int'(RegCount); i++) begin
              if (addr_q == 13'(i)) shadow_q[i*8 +: 8] <= dataShift_q;
            end
          end
          state_q <= DONE;
        end
        DONE: begin
          if (csS) begin
            misoOe_q <= 1'b0;
            miso_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= WAIT_CSH;
      endcase
    end
  end

  assign spi.miso      = miso_q;
  assign spi.miso_oe   = misoOe_q;
  assign wr_strobe_o   = wrStrobe_q;
  assign wr_addr_o     = wrAddr_q;
  assign wr_data_o     = wrData_q;
  assign update_o      = update_q;
  assign frame_err_o   = frameErr_q;
  assign active_regs_o = active_q;

endmodule

// File: tb/tb_ad9648_spi_responder.sv
// Scoreboard bench for the AD9648 SPI responder: stimulus pushes expected strobes, updates,
// frame errors and read bytes; independent monitors pop and compare as the DUT produces them.
module tb_ad9648_spi_responder;

  localparam int HalfSck = 6;

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
  } strobe_t;

  logic         clk;
  logic         rst_n;
  logic         wr_strobe;
  logic [12:0]  wr_addr;
  logic [7:0]   wr_data;
  logic         update;
  logic         frame_err;
  logic [127:0] active_regs;

  int testsRun    = 0;
  int testsFailed = 0;

  strobe_t     expStrobe[$];
  logic [7:0]  expRead[$];
  bit          expUpdate[$];
  bit          expErr[$];

  ad9648_spi_responder_if spiIf ();

  ad9648_spi_responder #(
    .RegCount (16),
    .ChipId   (8'h88),
    .FrameBits(24)
  ) dut (
    .clk_i        (clk),
    .rst_clk_i    (rst_n),
    .spi          (spiIf.slave),
    .wr_strobe_o  (wr_strobe),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .update_o     (update),
    .frame_err_o  (frame_err),
    .active_regs_o(active_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one mode-0 frame MSB-first; nRise < 24 stops early to model an abort or reset.
  task automatic applyStimulus(input logic [23:0] frame, input int nRise, input bit raiseCs);
    spiIf.cs = 1'b0;
    repeat (HalfSck) @(negedge clk);
    for (int i = 0; i < nRise; i++) begin
      spiIf.mosi = frame[23-i];
      repeat (HalfSck) @(negedge clk);
      spiIf.sck = 1'b1;
      repeat (HalfSck) @(negedge clk);
      spiIf.sck = 1'b0;
    end
    repeat (HalfSck) @(negedge clk);
    if (raiseCs) begin
      spiIf.cs = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic writeReg(input logic [12:0] addr, input logic [7:0] data);
    strobe_t s;
    s.addr = addr;
    s.data = data;
    expStrobe.push_back(s);
    applyStimulus({3'b000, addr, data}, 24, 1'b1);
  endtask

  task automatic readReg(input logic [12:0] addr, input logic [7:0] exp);
    expRead.push_back(exp);
    applyStimulus({3'b100, addr, 8'h00}, 24, 1'b1);
  endtask

  task automatic transfer(input logic [7:0] data);
    if (data[0]) expUpdate.push_back(1'b1);
    writeReg(13'h0FF, data);
  endtask

  // Pulse monitor: every strobe, update and frame error must match a queued expectation.
  initial begin
    strobe_t s;
    forever begin
      @(negedge clk);
      if (wr_strobe) begin
        if (expStrobe.size() == 0) begin
          checkOutput("unexpected wr_strobe", 128'(wr_addr), 128'h1FFFF);
        end else begin
          s = expStrobe.pop_front();
          checkOutput("wr_addr", 128'(wr_addr), 128'(s.addr));
          checkOutput("wr_data", 128'(wr_data), 128'(s.data));
        end
      end
      if (update) begin
        checkOutput("update expected", 128'(expUpdate.size() != 0), 128'(1));
        if (expUpdate.size() != 0) void'(expUpdate.pop_front());
      end
      if (frame_err) begin
        checkOutput("frame_err expected", 128'(expErr.size() != 0), 128'(1));
        if (expErr.size() != 0) void'(expErr.pop_front());
      end
    end
  end

  // Read monitor: collects MISO on SCK rising edges while the responder drives it.
  initial begin
    logic [7:0] rdByte;
    int         rdCnt;
    rdByte = '0;
    rdCnt  = 0;
    forever begin
      @(posedge spiIf.sck or posedge spiIf.cs);
      if (spiIf.cs) begin
        rdCnt = 0;
      end else if (spiIf.miso_oe) begin
        rdByte = {rdByte[6:0], spiIf.miso};
        rdCnt++;
        if (rdCnt == 8) begin
          rdCnt = 0;
          if (expRead.size() == 0) begin
            checkOutput("unexpected read", 128'(rdByte), 128'h1FF);
          end else begin
            checkOutput("read data", 128'(rdByte), 128'(expRead.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    spiIf.sck  = 1'b0;
    spiIf.cs   = 1'b1;
    spiIf.mosi = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset wr_strobe", 128'(wr_strobe), 128'(0));
    checkOutput("reset wr_addr", 128'(wr_addr), 128'(0));
    checkOutput("reset update", 128'(update), 128'(0));
    checkOutput("reset miso_oe", 128'(spiIf.miso_oe), 128'(0));
    checkOutput("reset miso", 128'(spiIf.miso), 128'(0));
    checkOutput("reset active", active_regs, 128'(0));
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    writeReg(13'h005, 8'hA5);
    checkOutput("active before transfer", active_regs, 128'(0));
    transfer(8'h01);
    checkOutput("active after transfer", active_regs, 128'hA5 << 40);

    readReg(13'h001, 8'h88);
    checkOutput("active after chip id read", active_regs, 128'hA5 << 40);

    writeReg(13'h003, 8'h3C);
    readReg(13'h003, 8'h3C);
    checkOutput("active byte3 not yet transferred", active_regs, 128'hA5 << 40);

    expErr.push_back(1'b1);
    applyStimulus({3'b000, 13'h002, 8'h77}, 10, 1'b1);
    readReg(13'h002, 8'h00);
    writeReg(13'h002, 8'h77);
    readReg(13'h002, 8'h77);

    writeReg(13'h001, 8'h55);
    writeReg(13'h200, 8'h11);
    readReg(13'h001, 8'h88);
    readReg(13'h200, 8'h00);
    readReg(13'h0FF, 8'h00);
    checkOutput("active after ignored writes", active_regs, 128'hA5 << 40);

    applyStimulus({3'b000, 13'h004, 8'h99}, 12, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid-frame reset active", active_regs, 128'(0));
    checkOutput("mid-frame reset wr_data", 128'(wr_data), 128'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      spiIf.mosi = 1'b1;
      spiIf.sck  = 1'b1;
      repeat (HalfSck) @(negedge clk);
      spiIf.sck  = 1'b0;
      repeat (HalfSck) @(negedge clk);
    end
    spiIf.cs = 1'b1;
    repeat (10) @(negedge clk);

    writeReg(13'h004, 8'h99);
    readReg(13'h004, 8'h99);
    readReg(13'h005, 8'h00);
    transfer(8'h01);
    checkOutput("active after second transfer", active_regs, 128'h99 << 32);
    writeReg(13'h004, 8'h11);
    transfer(8'h00);
    checkOutput("active after no-op transfer", active_regs, 128'h99 << 32);
    readReg(13'h004, 8'h11);

    repeat (20) @(negedge clk);
    checkOutput("strobes outstanding", 128'(expStrobe.size()), 128'(0));
    checkOutput("reads outstanding", 128'(expRead.size()), 128'(0));
    checkOutput("updates outstanding", 128'(expUpdate.size()), 128'(0));
    checkOutput("frame errors outstanding", 128'(expErr.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
